// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
//   Shares the single register-file write port between the writeback stage
//   (WB) and the multi-cycle multiply/divide unit (MDU). MDU results are held
//   in a small FIFO. WB normally wins. A starvation counter and a WAW check on
//   the buffered addresses stall WB so the FIFO can drain.
// Ports
//   clk, rst                  clock (rising edge), async active-high reset
//   wb_valid/addr/data        WB write request; wb_stall asks WB to hold it
//   mdu_valid/addr/data       MDU result; captured only when mdu_ready=1
//   mdu_ready                 registered FIFO not-full
//   rf_we/rf_waddr/rf_wdata   RegFile write port, committed at the next edge
//   pending_cnt               FIFO occupancy
module rf_write_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wb_valid,
  input  logic [ADDR_W-1:0]             wb_addr,
  input  logic [DATA_W-1:0]             wb_data,
  output logic                          wb_stall,
  input  logic                          mdu_valid,
  input  logic [ADDR_W-1:0]             mdu_addr,
  input  logic [DATA_W-1:0]             mdu_data,
  output logic                          mdu_ready,
  output logic                          rf_we,
  output logic [ADDR_W-1:0]             rf_waddr,
  output logic [DATA_W-1:0]             rf_wdata,
  output logic [$clog2(FIFO_DEPTH):0]   pending_cnt
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ST_W  = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ent_t;

  typedef enum logic {NORMAL, FORCE} state_t;

  ent_t                  mem_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] occ_q, occ_d;
  logic [PTR_W-1:0]      rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ready_q;
  state_t                state_q, state_d;
  logic [ST_W-1:0]       starve_q, starve_d;

  logic empty, push, pop, grant_wb, stall_c, addr_hit, waw_hit;
  ent_t sel;

  assign empty = (cnt_q == '0);
  // ready_q is the registered not-full, so a full FIFO never pushes even if
  // it pops in the same cycle.
  assign push  = mdu_valid && ready_q;

  // WAW: WB targets a register that an older buffered MDU result will write.
  always_comb begin
    addr_hit = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++)
      if (occ_q[i] && (mem_q[i].addr == wb_addr)) addr_hit = 1'b1;
  end
  assign waw_hit = wb_valid && (wb_addr != '0) && addr_hit;

  always_comb begin
    pop      = 1'b0;
    grant_wb = 1'b0;
    stall_c  = 1'b0;
    state_d  = state_q;
    starve_d = starve_q;
    case (state_q)
      NORMAL: begin
        if (waw_hit) begin
          pop     = 1'b1;
          stall_c = 1'b1;
        end else if (wb_valid) begin
          grant_wb = 1'b1;
        end else if (!empty) begin
          pop = 1'b1;
        end
        if (grant_wb && !empty) begin
          if (starve_q == ST_W'(STARVE_LIMIT - 1)) begin
            state_d  = FORCE;
            starve_d = '0;
          end else begin
            starve_d = starve_q + 1'b1;
          end
        end else if (pop || empty) begin
          starve_d = '0;
        end
      end
      FORCE: begin
        // FIFO is non-empty here: WB won the entry cycle, so nothing popped.
        pop      = 1'b1;
        stall_c  = wb_valid;
        state_d  = NORMAL;
        starve_d = '0;
      end
      default: state_d = NORMAL;
    endcase
  end

  assign sel = grant_wb ? ent_t'{addr: wb_addr, data: wb_data} : mem_q[rd_ptr_q];

  // Writes to r0 still complete their handshake but never reach the RegFile.
  assign rf_we       = !rst && (grant_wb || pop) && (sel.addr != '0);
  assign rf_waddr    = sel.addr;
  assign rf_wdata    = sel.data;
  assign wb_stall    = !rst && stall_c;
  assign mdu_ready   = ready_q;
  assign pending_cnt = cnt_q;

  always_comb begin
    occ_d = occ_q;
    if (pop)  occ_d[rd_ptr_q] = 1'b0;
    if (push) occ_d[wr_ptr_q] = 1'b1;
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      state_q  <= NORMAL;
      starve_q <= '0;
    end else begin
      occ_q    <= occ_d;
      cnt_q    <= cnt_d;
      ready_q  <= (cnt_d != CNT_W'(FIFO_DEPTH));
      state_q  <= state_d;
      starve_q <= starve_d;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
    end
  end

  // Payload storage needs no reset; occ_q qualifies every entry.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= ent_t'{addr: mdu_addr, data: mdu_data};
  end

`ifndef SYNTHESIS
  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) pop |-> !empty);
`endif
endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;
  logic        clk, rst;
  logic        wb_valid, wb_stall, mdu_valid, mdu_ready, rf_we;
  logic [4:0]  wb_addr, mdu_addr, rf_waddr;
  logic [31:0] wb_data, mdu_data, rf_wdata;
  logic [1:0]  pending_cnt;

  int errors = 0;
  int checks = 0;
  logic [31:0] rf_model [32];

  rf_write_arbiter dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_stall(wb_stall),
    .mdu_valid(mdu_valid), .mdu_addr(mdu_addr), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pending_cnt(pending_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial for (int i = 0; i < 32; i++) rf_model[i] = '0;
  always @(posedge clk) if (rf_we && !rst) rf_model[rf_waddr] <= rf_wdata;

  typedef struct {
    logic wv; logic [4:0] wa; logic [31:0] wd;
    logic mv; logic [4:0] ma; logic [31:0] md;
    logic we; logic [4:0] a;  logic [31:0] d;
    logic st; logic rdy;      logic [1:0] cnt;
  } vec_t;

  function automatic vec_t mk(logic wv, logic [4:0] wa, logic [31:0] wd,
                              logic mv, logic [4:0] ma, logic [31:0] md,
                              logic we, logic [4:0] a, logic [31:0] d,
                              logic st, logic rdy, logic [1:0] cnt);
    vec_t v;
    v.wv = wv; v.wa = wa; v.wd = wd; v.mv = mv; v.ma = ma; v.md = md;
    v.we = we; v.a = a; v.d = d; v.st = st; v.rdy = rdy; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(logic wv, logic [4:0] wa, logic [31:0] wd,
                       logic mv, logic [4:0] ma, logic [31:0] md);
    wb_valid = wv; wb_addr = wa; wb_data = wd;
    mdu_valid = mv; mdu_addr = ma; mdu_data = md;
  endtask

  task automatic chk_out(string nm, logic we, logic [4:0] a, logic [31:0] d,
                         logic st, logic rdy, logic [1:0] cnt);
    chk({nm, " rf_we"}, 32'(rf_we), 32'(we));
    if (we) begin
      chk({nm, " rf_waddr"}, 32'(rf_waddr), 32'(a));
      chk({nm, " rf_wdata"}, rf_wdata, d);
    end
    chk({nm, " wb_stall"}, 32'(wb_stall), 32'(st));
    chk({nm, " mdu_ready"}, 32'(mdu_ready), 32'(rdy));
    chk({nm, " pending_cnt"}, 32'(pending_cnt), 32'(cnt));
  endtask

  vec_t v [25];

  initial begin
    // Tests 1-5 plus a push/pop-same-cycle ordering check, one row per cycle.
    v[0]  = mk(0,0,0,         0,0,0,          0,0,0,          0,1,0);
    v[1]  = mk(1,5,'h1234,    0,0,0,          1,5,'h1234,     0,1,0);
    v[2]  = mk(0,0,0,         1,8,'hCAFE,     0,0,0,          0,1,0);
    v[3]  = mk(0,0,0,         0,0,0,          1,8,'hCAFE,     0,1,1);
    v[4]  = mk(0,0,0,         0,0,0,          0,0,0,          0,1,0);
    v[5]  = mk(0,0,0,         1,9,'h99,       0,0,0,          0,1,0);
    v[6]  = mk(1,1,'hA1,      0,0,0,          1,1,'hA1,       0,1,1);
    v[7]  = mk(1,2,'hA2,      0,0,0,          1,2,'hA2,       0,1,1);
    v[8]  = mk(1,3,'hA3,      0,0,0,          1,3,'hA3,       0,1,1);
    v[9]  = mk(1,4,'hA4,      0,0,0,          1,4,'hA4,       0,1,1);
    v[10] = mk(1,5,'hA5,      0,0,0,          1,9,'h99,       1,1,1);
    v[11] = mk(1,5,'hA5,      0,0,0,          1,5,'hA5,       0,1,0);
    v[12] = mk(0,0,0,         1,7,'h11,       0,0,0,          0,1,0);
    v[13] = mk(1,7,'h22,      0,0,0,          1,7,'h11,       1,1,1);
    v[14] = mk(1,7,'h22,      0,0,0,          1,7,'h22,       0,1,0);
    v[15] = mk(1,2,'h2,       1,10,'hB0,      1,2,'h2,        0,1,0);
    v[16] = mk(1,2,'h3,       1,0,'hB1,       1,2,'h3,        0,1,1);
    v[17] = mk(1,2,'h4,       1,11,'hB2,      1,2,'h4,        0,0,2);
    v[18] = mk(0,0,0,         1,11,'hB2,      1,10,'hB0,      0,0,2);
    v[19] = mk(0,0,0,         0,0,0,          0,0,0,          0,1,1);
    v[20] = mk(0,0,0,         0,0,0,          0,0,0,          0,1,0);
    v[21] = mk(0,0,0,         1,12,'hC0,      0,0,0,          0,1,0);
    v[22] = mk(0,0,0,         1,13,'hC1,      1,12,'hC0,      0,1,1);
    v[23] = mk(0,0,0,         0,0,0,          1,13,'hC1,      0,1,1);
    v[24] = mk(0,0,0,         0,0,0,          0,0,0,          0,1,0);

    // Reset with a WB request pending: outputs must stay quiet.
    rst = 1'b1;
    drive(1, 5, 'h55, 1, 3, 'h33);
    repeat (2) @(negedge clk);
    #2 chk_out("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #2 chk_out("post_reset_pre_edge", 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      drive(v[i].wv, v[i].wa, v[i].wd, v[i].mv, v[i].ma, v[i].md);
      #2 chk_out($sformatf("vec%0d", i), v[i].we, v[i].a, v[i].d, v[i].st, v[i].rdy, v[i].cnt);
    end

    // Reset while in FORCE with two buffered entries.
    @(negedge clk); drive(1, 1, 'hD1, 1, 14, 'hE0);
    #2 chk_out("rst6_a", 1, 1, 'hD1, 0, 1, 0);
    @(negedge clk); drive(1, 1, 'hD1, 1, 15, 'hE1);
    #2 chk_out("rst6_b", 1, 1, 'hD1, 0, 1, 1);
    @(negedge clk); drive(1, 1, 'hD1, 0, 0, 0);
    #2 chk_out("rst6_c", 1, 1, 'hD1, 0, 0, 2);
    @(negedge clk);
    #2 chk_out("rst6_d", 1, 1, 'hD1, 0, 0, 2);
    @(negedge clk);
    #2 chk_out("rst6_e", 1, 1, 'hD1, 0, 0, 2);
    @(negedge clk);
    #1 chk_out("rst6_force", 1, 14, 'hE0, 1, 0, 2);
    rst = 1'b1;
    #1 chk_out("rst6_async", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #2 chk_out("rst6_release", 0, 0, 0, 0, 0, 0);
    @(negedge clk); drive(1, 3, 'hD3, 0, 0, 0);
    #2 chk_out("rst6_wb", 1, 3, 'hD3, 0, 1, 0);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0);
    #2 chk_out("rst6_idle", 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    #2 chk_out("rst6_idle2", 0, 0, 0, 0, 1, 0);

    // Architectural results seen by the RegFile.
    chk("final_r7", rf_model[7], 'h22);
    chk("final_r9", rf_model[9], 'h99);
    chk("final_r8", rf_model[8], 'hCAFE);
    chk("final_r2", rf_model[2], 'h4);
    chk("final_r0", rf_model[0], 'h0);
    chk("final_r14_stale", rf_model[14], 'h0);
    chk("final_r15_stale", rf_model[15], 'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
